// File: rtl/ps2_key_decoder_if.sv
// ============================================================================
// Module   : ps2_key_decoder_if
// Purpose  : PS/2 line inputs and decoded digit-key / frame-error outputs.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

interface ps2_key_decoder_if;
    logic ps2_clk;
    logic ps2_data;
    logic key_1;
    logic key_2;
    logic key_3;
    logic key_4;
    logic key_5;
    logic key_6;
    logic key_7;
    logic key_8;
    logic key_9;
    logic frame_err;

    // The decoder consumes the PS/2 lines and produces the key pulses.
    modport slave (
        input  ps2_clk,
        input  ps2_data,
        output key_1,
        output key_2,
        output key_3,
        output key_4,
        output key_5,
        output key_6,
        output key_7,
        output key_8,
        output key_9,
        output frame_err
    );

    modport master (
        output ps2_clk,
        output ps2_data,
        input  key_1,
        input  key_2,
        input  key_3,
        input  key_4,
        input  key_5,
        input  key_6,
        input  key_7,
        input  key_8,
        input  key_9,
        input  frame_err
    );
endinterface

`default_nettype wire

// File: rtl/ps2_key_decoder.sv
// ============================================================================
// Module   : ps2_key_decoder
// Purpose  : PS/2 set-2 receiver decoding digit make codes 1-9 into one-cycle
//            key pulses. Optional macro TYPEMATIC_FILTER_EN suppresses repeats.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module ps2_key_decoder #(
    parameter int FILTER_LEN  = 8,
    parameter int TIMEOUT_CYC = 50000,
    parameter int TO_W        = 16
) (
    input  logic               clk,
    input  logic               clr,
    ps2_key_decoder_if.slave   bus
);

    localparam int                   c_FILT_W    = $clog2(FILTER_LEN + 1);
    localparam logic [c_FILT_W-1:0]  c_FILT_LAST = c_FILT_W'(FILTER_LEN - 1);
    localparam logic [TO_W-1:0]      c_TO_LAST   = TO_W'(TIMEOUT_CYC - 1);
    localparam logic [7:0]           c_BRK_CODE  = 8'hF0;
    localparam logic [7:0]           c_EXT_CODE  = 8'hE0;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_DATA   = 2'd1,
        S_PARITY = 2'd2,
        S_STOP   = 2'd3
    } state_t;

    state_t                r_state;
    state_t                w_state_next;

    logic                  r_clk_s1;
    logic                  r_clk_s2;
    logic                  r_dat_s1;
    logic                  r_dat_s2;
    logic                  r_filt;
    logic [c_FILT_W-1:0]   r_filt_cnt;
    logic [7:0]            r_shift;
    logic [2:0]            r_bit_cnt;
    logic                  r_parity;
    logic [TO_W-1:0]       r_to_cnt;
    logic                  r_brk;
    logic                  r_ext;
    logic [7:0]            r_held;
    logic [8:0]            r_keys;
    logic                  r_frame_err;

    logic                  w_fall;
    logic                  w_timeout;
    logic                  w_stop_fall;
    logic                  w_frame_ok;
    logic                  w_err;
    logic                  w_is_make;
    logic                  w_suppress;
    logic [8:0]            w_key_hit;

    // ------------------------------------------------------------------
    // Two-flop synchronisers; idle PS/2 lines are high.
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            r_clk_s1 <= 1'b1;
            r_clk_s2 <= 1'b1;
            r_dat_s1 <= 1'b1;
            r_dat_s2 <= 1'b1;
        end else begin
            r_clk_s1 <= bus.ps2_clk;
            r_clk_s2 <= r_clk_s1;
            r_dat_s1 <= bus.ps2_data;
            r_dat_s2 <= r_dat_s1;
        end
    end

    // ------------------------------------------------------------------
    // Glitch filter: the level flips on the FILTER_LEN-th consecutive
    // sample that disagrees with it; any agreeing sample restarts the run.
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            r_filt     <= 1'b1;
            r_filt_cnt <= '0;
        end else if (r_clk_s2 == r_filt) begin
            r_filt_cnt <= '0;
        end else if (r_filt_cnt == c_FILT_LAST) begin
            r_filt     <= r_clk_s2;
            r_filt_cnt <= '0;
        end else begin
            r_filt_cnt <= r_filt_cnt + 1'b1;
        end
    end

    assign w_fall = r_filt & ~r_clk_s2 & (r_filt_cnt == c_FILT_LAST);

    // ------------------------------------------------------------------
    // Frame state machine
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_stop_fall  = 1'b0;
        // A fall on the terminal count restarts the count instead of aborting.
        w_timeout    = (r_state != S_IDLE) && !w_fall && (r_to_cnt == c_TO_LAST);
        case (r_state)
            S_IDLE: begin
                if (w_fall && !r_dat_s2) begin
                    w_state_next = S_DATA;
                end
            end
            S_DATA: begin
                if (w_fall && (r_bit_cnt == 3'd7)) begin
                    w_state_next = S_PARITY;
                end
            end
            S_PARITY: begin
                if (w_fall) begin
                    w_state_next = S_STOP;
                end
            end
            S_STOP: begin
                if (w_fall) begin
                    w_state_next = S_IDLE;
                    w_stop_fall  = 1'b1;
                end
            end
            default: begin
                w_state_next = S_IDLE;
            end
        endcase
        if (w_timeout) begin
            w_state_next = S_IDLE;
        end
    end

    // Odd parity: data bits plus parity bit must hold an odd number of ones.
    assign w_frame_ok = w_stop_fall && r_dat_s2 && (^{r_shift, r_parity});
    assign w_err      = (w_stop_fall && !w_frame_ok) || w_timeout;
    assign w_is_make  = w_frame_ok && (r_shift != c_BRK_CODE) &&
                        (r_shift != c_EXT_CODE) && !r_brk && !r_ext;

`ifdef TYPEMATIC_FILTER_EN
    assign w_suppress = (r_shift == r_held);
`else
    assign w_suppress = 1'b0;
`endif

    // Keypad and top-row set-2 make codes for digits 1-9.
    always_comb begin
        w_key_hit = '0;
        case (r_shift)
            8'h69, 8'h16: w_key_hit[0] = 1'b1;
            8'h72, 8'h1E: w_key_hit[1] = 1'b1;
            8'h7A, 8'h26: w_key_hit[2] = 1'b1;
            8'h6B, 8'h25: w_key_hit[3] = 1'b1;
            8'h73, 8'h2E: w_key_hit[4] = 1'b1;
            8'h74, 8'h36: w_key_hit[5] = 1'b1;
            8'h6C, 8'h3D: w_key_hit[6] = 1'b1;
            8'h75, 8'h3E: w_key_hit[7] = 1'b1;
            8'h7D, 8'h46: w_key_hit[8] = 1'b1;
            default:      w_key_hit    = '0;
        endcase
    end

    // ------------------------------------------------------------------
    // Shift register, bit counter, parity latch and timeout counter
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            r_shift   <= '0;
            r_bit_cnt <= '0;
            r_parity  <= 1'b0;
            r_to_cnt  <= '0;
        end else begin
            if ((r_state == S_IDLE) && w_fall && !r_dat_s2) begin
                r_shift   <= '0;
                r_bit_cnt <= '0;
            end else if ((r_state == S_DATA) && w_fall) begin
                r_shift   <= {r_dat_s2, r_shift[7:1]};
                r_bit_cnt <= r_bit_cnt + 3'd1;
            end

            if ((r_state == S_PARITY) && w_fall) begin
                r_parity <= r_dat_s2;
            end

            if ((r_state == S_IDLE) || w_fall || w_timeout) begin
                r_to_cnt <= '0;
            end else begin
                r_to_cnt <= r_to_cnt + 1'b1;
            end
        end
    end

    // ------------------------------------------------------------------
    // Prefix tracking, held key and registered output pulses
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            r_brk       <= 1'b0;
            r_ext       <= 1'b0;
            r_held      <= '0;
            r_keys      <= '0;
            r_frame_err <= 1'b0;
        end else begin
            r_frame_err <= w_err;
            r_keys      <= (w_is_make && !w_suppress) ? w_key_hit : '0;

            if (w_err) begin
                r_brk <= 1'b0;
                r_ext <= 1'b0;
            end else if (w_frame_ok) begin
                if (r_shift == c_BRK_CODE) begin
                    r_brk <= 1'b1;
                end else if (r_shift == c_EXT_CODE) begin
                    r_ext <= 1'b1;
                end else if (r_brk || r_ext) begin
                    r_brk <= 1'b0;
                    r_ext <= 1'b0;
                    if (r_brk && (r_shift == r_held)) begin
                        r_held <= '0;
                    end
                end else begin
                    r_held <= r_shift;
                end
            end
        end
    end

    assign bus.key_1     = r_keys[0];
    assign bus.key_2     = r_keys[1];
    assign bus.key_3     = r_keys[2];
    assign bus.key_4     = r_keys[3];
    assign bus.key_5     = r_keys[4];
    assign bus.key_6     = r_keys[5];
    assign bus.key_7     = r_keys[6];
    assign bus.key_8     = r_keys[7];
    assign bus.key_9     = r_keys[8];
    assign bus.frame_err = r_frame_err;

endmodule

`default_nettype wire

// File: tb/tb_ps2_key_decoder.sv
// ============================================================================
// Module   : tb_ps2_key_decoder
// Purpose  : Directed PS/2 frame stimulus with pulse counting for the decoder.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_ps2_key_decoder;

    logic clk = 1'b0;
    logic clr = 1'b0;
    always #5 clk = ~clk;

    ps2_key_decoder_if bus ();

    ps2_key_decoder #(
        .FILTER_LEN  (8),
        .TIMEOUT_CYC (1000),
        .TO_W        (16)
    ) dut (
        .clk (clk),
        .clr (clr),
        .bus (bus)
    );

    logic [8:0] keys;
    assign keys = {bus.key_9, bus.key_8, bus.key_7, bus.key_6, bus.key_5,
                   bus.key_4, bus.key_3, bus.key_2, bus.key_1};

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;
    int kcnt [9];
    int k0   [9];
    int ecnt     = 0;
    int e0       = 0;
    int multi    = 0;
    int rise1    = -1;
    int stop_cyc = 0;

    initial begin
        for (int i = 0; i < 9; i++) begin
            kcnt[i] = 0;
            k0[i]   = 0;
        end
    end

    // Output monitor samples on the inactive edge.
    always @(negedge clk) begin
        cyc++;
        for (int i = 0; i < 9; i++) begin
            if (keys[i]) kcnt[i]++;
        end
        if (bus.frame_err) ecnt++;
        if ($countones(keys) > 1) multi++;
        if (keys[0] && (rise1 < 0)) rise1 = cyc;
    end

    task automatic check(input string tag, input int obs, input int exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic snap();
        for (int i = 0; i < 9; i++) k0[i] = kcnt[i];
        e0 = ecnt;
    endtask

    function automatic int dk(input int i);
        return kcnt[i] - k0[i];
    endfunction

    function automatic int dk_all();
        int s = 0;
        for (int i = 0; i < 9; i++) s += kcnt[i] - k0[i];
        return s;
    endfunction

    // One PS/2 bit: data set mid-high, clock low 40 clk, high 40 clk.
    task automatic ps2_bit(input logic v);
        @(negedge clk);
        bus.ps2_data = v;
        repeat (20) @(negedge clk);
        bus.ps2_clk = 1'b0;
        stop_cyc = cyc;
        repeat (40) @(negedge clk);
        bus.ps2_clk = 1'b1;
        repeat (20) @(negedge clk);
    endtask

    task automatic send_frame(input logic [7:0] b, input logic bad_par, input logic stop);
        ps2_bit(1'b0);
        for (int i = 0; i < 8; i++) ps2_bit(b[i]);
        ps2_bit((~^b) ^ bad_par);
        ps2_bit(stop);
        bus.ps2_data = 1'b1;
        repeat (200) @(negedge clk);
    endtask

    initial begin
        logic [7:0] b;
        int lat;
        bus.ps2_clk  = 1'b1;
        bus.ps2_data = 1'b1;
        clr          = 1'b0;
        repeat (3) @(negedge clk);
        #1;
        check("reset_keys", int'(keys), 0);
        check("reset_frame_err", int'(bus.frame_err), 0);
        @(negedge clk);
        clr = 1'b1;
        repeat (20) @(negedge clk);

        // Keypad 1
        snap();
        rise1 = -1;
        send_frame(8'h69, 1'b0, 1'b1);
        check("k1_pulse_count", dk(0), 1);
        check("k1_others", dk_all() - dk(0), 0);
        check("k1_no_err", ecnt - e0, 0);
        lat = rise1 - stop_cyc;
        check("k1_after_stop_fall", int'((lat >= 3) && (lat <= 14)), 1);

        // Break of keypad 5, then top-row 5
        snap();
        send_frame(8'hF0, 1'b0, 1'b1);
        send_frame(8'h73, 1'b0, 1'b1);
        check("break_no_pulse", dk_all(), 0);
        snap();
        send_frame(8'h2E, 1'b0, 1'b1);
        check("k5_toprow", dk(4), 1);
        check("k5_toprow_only", dk_all(), 1);

        // Bad parity and bad stop
        snap();
        send_frame(8'h72, 1'b1, 1'b1);
        check("parity_err", ecnt - e0, 1);
        check("parity_no_key2", dk(1), 0);
        snap();
        send_frame(8'h72, 1'b0, 1'b0);
        check("stop_err", ecnt - e0, 1);
        check("stop_no_key", dk_all(), 0);

        // Truncated frame aborted by timeout
        snap();
        b = 8'h5A;
        ps2_bit(1'b0);
        for (int i = 0; i < 4; i++) ps2_bit(b[i]);
        bus.ps2_data = 1'b1;
        repeat (1200) @(negedge clk);
        check("timeout_err", ecnt - e0, 1);
        check("timeout_no_key", dk_all(), 0);
        snap();
        send_frame(8'h7D, 1'b0, 1'b1);
        check("k9_after_timeout", dk(8), 1);
        check("k9_no_err", ecnt - e0, 0);

        // Extended prefix suppresses the following code
        snap();
        send_frame(8'hE0, 1'b0, 1'b1);
        send_frame(8'h69, 1'b0, 1'b1);
        check("ext_no_pulse", dk_all(), 0);

        // Typematic repeat, break, press again, repeat
        snap();
        send_frame(8'h73, 1'b0, 1'b1);
        send_frame(8'h73, 1'b0, 1'b1);
        send_frame(8'hF0, 1'b0, 1'b1);
        send_frame(8'h73, 1'b0, 1'b1);
        send_frame(8'h73, 1'b0, 1'b1);
`ifdef TYPEMATIC_FILTER_EN
        check("typematic_k5", dk(4), 2);
`else
        check("typematic_k5", dk(4), 3);
`endif
        check("typematic_only_k5", dk_all() - dk(4), 0);

        // Reset in the middle of keypad 8, then keypad 7
        snap();
        b = 8'h75;
        ps2_bit(1'b0);
        for (int i = 0; i < 6; i++) ps2_bit(b[i]);
        @(negedge clk);
        clr = 1'b0;
        #1;
        check("midrst_keys", int'(keys), 0);
        check("midrst_err", int'(bus.frame_err), 0);
        repeat (3) @(negedge clk);
        #1;
        check("midrst_keys_late", int'(keys), 0);
        clr = 1'b1;
        ps2_bit(b[6]);
        ps2_bit(b[7]);
        ps2_bit(~^b);
        ps2_bit(1'b1);
        bus.ps2_data = 1'b1;
        repeat (1200) @(negedge clk);
        send_frame(8'h6C, 1'b0, 1'b1);
        check("midrst_no_k8", dk(7), 0);
        check("midrst_k7", dk(6), 1);

        check("one_hot_keys", multi, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

`default_nettype wire
